ps2_scan_receiver: RTL and testbench

Parametrised PS/2 keyboard receiver running entirely in the system clock domain. It synchronises and glitch-filters the raw PS/2 lines and validates each 11-bit frame: start bit, odd parity, stop bit, and an inter-bit timeout. E0 (extended) and F0 (break) prefixes are folded into flags. Completed key events are buffered in a FIFO with a valid/ready output toward the input-handling logic.

---
 rtl/ps2_pkg.sv | 30 +++
 rtl/ps2_scan_receiver_if.sv | 19 +
 rtl/ps2_event_fifo.sv | 60 ++++++
 rtl/ps2_scan_receiver.sv | 191 +++++++++++++++++++
 tb/tb_ps2_scan_receiver.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 scan-code receiver.
//   - Prefix byte constants (extended / break)
//   - Frame-decoder state enum
//   - Packed key-event record stored in the event FIFO
//   - frame_ok(): stop-bit and odd-parity check for a completed frame
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  // Valid frame: stop bit high and an odd number of ones across data+parity.
  function automatic logic frame_ok(input logic [7:0] data, input logic parity,
                                    input logic stop_bit);
    return stop_bit & (^{data, parity});
  endfunction

endpackage

// File: rtl/ps2_scan_receiver_if.sv
// ps2_scan_receiver_if: valid/ready key-event stream.
//   code_data  : scan code at FIFO head
//   code_ext   : head event preceded by E0
//   code_break : head event preceded by F0
//   code_valid : an event is available
//   code_ready : consumer accepts the head event
// master = receiver side, slave = consumer side.
interface ps2_scan_receiver_if;
  logic [7:0] code_data;
  logic       code_ext;
  logic       code_break;
  logic       code_valid;
  logic       code_ready;

  modport master (output code_data, output code_ext, output code_break,
                  output code_valid, input code_ready);
  modport slave  (input code_data, input code_ext, input code_break,
                  input code_valid, output code_ready);
endinterface

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: synchronous first-word-fall-through FIFO.
//   clk, reset     : clock, synchronous active-high reset
//   push/push_data : write request and data (accepted if not full, or full with pop)
//   pop            : remove head entry (ignored when empty)
//   head           : head entry, zero when empty
//   full, empty    : status flags
//   count          : number of entries held
module ps2_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               head,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;
  logic             w_push;

  assign empty  = (r_count == '0);
  assign full   = (r_count == CW'(DEPTH));
  assign w_pop  = pop & ~empty;
  // A full FIFO still takes a write when the head leaves on the same cycle.
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = empty ? '0 : r_mem[r_rd_ptr];
  assign count = r_count;
endmodule

// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver: PS/2 keyboard receiver in the system clock domain.
//   clk, reset : system clock, synchronous active-high reset
//   ps2_clk    : raw PS/2 clock (asynchronous)
//   ps2_data   : raw PS/2 data (asynchronous)
//   codes      : key-event valid/ready stream (master side)
//   frame_err  : one-cycle pulse when a frame is aborted
//   overflow   : one-cycle pulse when an event is dropped on a full FIFO
//   fifo_count : events held in the FIFO
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              ps2_clk,
  input  logic                              ps2_data,
  ps2_scan_receiver_if.master               codes,
  output logic                              frame_err,
  output logic                              overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES);

  // Line 0 = ps2_clk, line 1 = ps2_data; both get identical sync + filter.
  logic [1:0] w_raw;
  logic [1:0] w_filt;
  assign w_raw = {ps2_data, ps2_clk};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      logic [SYNC_STAGES-1:0] r_sync;
      logic [FCW-1:0]         r_cnt;
      logic                   r_filt;
      always_ff @(posedge clk) begin
        if (reset) begin
          r_sync <= '1;
          r_cnt  <= '0;
          r_filt <= 1'b1;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[gi]};
          // Any sample matching the current level restarts the run.
          if (r_sync[SYNC_STAGES-1] != r_filt) begin
            if (r_cnt == FCW'(FILTER_LEN - 1)) begin
              r_filt <= r_sync[SYNC_STAGES-1];
              r_cnt  <= '0;
            end else begin
              r_cnt <= r_cnt + FCW'(1);
            end
          end else begin
            r_cnt <= '0;
          end
        end
      end
      assign w_filt[gi] = r_filt;
    end
  endgenerate

  logic w_clk_f, w_data_f, r_clk_f_d, w_edge;
  assign w_clk_f  = w_filt[0];
  assign w_data_f = w_filt[1];
  assign w_edge   = r_clk_f_d & ~w_clk_f;

  ps2_state_t r_state;
  logic [2:0]     r_bit_idx;
  logic [7:0]     r_shift;
  logic           r_parity;
  logic [TCW-1:0] r_to_cnt;
  logic           r_byte_valid;
  logic [7:0]     r_byte;
  logic           r_frame_err;
  logic           w_timeout;

  // An edge landing on the last allowed cycle still counts as in time.
  assign w_timeout = (r_state != IDLE) && !w_edge &&
                     (r_to_cnt == TCW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_f_d    <= 1'b1;
      r_state      <= IDLE;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_to_cnt     <= '0;
      r_byte_valid <= 1'b0;
      r_byte       <= '0;
      r_frame_err  <= 1'b0;
    end else begin
      r_clk_f_d    <= w_clk_f;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_timeout) begin
        r_state     <= IDLE;
        r_to_cnt    <= '0;
        r_frame_err <= 1'b1;
      end else begin
        if (w_edge || r_state == IDLE) r_to_cnt <= '0;
        else                           r_to_cnt <= r_to_cnt + TCW'(1);
        if (w_edge) begin
          case (r_state)
            IDLE: begin
              if (!w_data_f) begin
                r_state   <= DATA;
                r_bit_idx <= '0;
              end
            end
            DATA: begin
              r_shift   <= {w_data_f, r_shift[7:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
              if (r_bit_idx == 3'd7) r_state <= PARITY;
            end
            PARITY: begin
              r_parity <= w_data_f;
              r_state  <= STOP;
            end
            default: begin
              if (frame_ok(r_shift, r_parity, w_data_f)) begin
                r_byte_valid <= 1'b1;
                r_byte       <= r_shift;
              end else begin
                r_frame_err <= 1'b1;
              end
              r_state <= IDLE;
            end
          endcase
        end
      end
    end
  end

  // Prefix folding: E0/F0 only arm flags; every other byte is an event.
  logic       r_ext_pend, r_brk_pend, r_overflow;
  logic       w_push, w_pop, w_full, w_empty;
  ps2_event_t w_push_evt, w_head;

  assign w_push = r_byte_valid && (r_byte != PS2_EXT_PREFIX) &&
                  (r_byte != PS2_BREAK_PREFIX);
  assign w_push_evt = '{ext: r_ext_pend, brk: r_brk_pend, code: r_byte};
  assign w_pop  = codes.code_ready & ~w_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_push && w_full && !w_pop;
      if (r_frame_err) begin
        r_ext_pend <= 1'b0;
        r_brk_pend <= 1'b0;
      end else if (r_byte_valid) begin
        if (r_byte == PS2_EXT_PREFIX) begin
          r_ext_pend <= 1'b1;
        end else if (r_byte == PS2_BREAK_PREFIX) begin
          r_brk_pend <= 1'b1;
        end else begin
          r_ext_pend <= 1'b0;
          r_brk_pend <= 1'b0;
        end
      end
    end
  end

  ps2_event_fifo #(
    .WIDTH ($bits(ps2_event_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (w_push_evt),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (fifo_count)
  );

  assign codes.code_data  = w_head.code;
  assign codes.code_ext   = w_head.ext;
  assign codes.code_break = w_head.brk;
  assign codes.code_valid = ~w_empty;
  assign frame_err        = r_frame_err;
  assign overflow         = r_overflow;
endmodule

// File: tb/tb_ps2_scan_receiver.sv
module tb_ps2_scan_receiver;
  localparam int FIFO_DEPTH = 8;
  localparam int SYNC_STAGES = 2;
  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT_CYCLES = 200;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       frame_err, overflow;
  logic [3:0] fifo_count;

  ps2_scan_receiver_if u_if ();

  ps2_scan_receiver #(
    .FIFO_DEPTH     (FIFO_DEPTH),
    .SYNC_STAGES    (SYNC_STAGES),
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .codes      (u_if),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int err_pulses = 0;
  int ovf_pulses = 0;

  always @(negedge clk) begin
    if (frame_err) err_pulses++;
    if (overflow)  ovf_pulses++;
  end

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end else begin
      $display("ok   %s: %0h", name, actual);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Full 11-bit frame. With pop_on_stop, code_ready is raised for exactly the
  // cycle on which the stop-bit event is pushed into the FIFO.
  task automatic send_frame(input logic [7:0] code, input bit bad_par,
                            input bit stop_bit, input bit pop_on_stop);
    logic [10:0] b;
    b = {stop_bit, (~^code) ^ bad_par, code, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1 ps2_data = b[i];
      wait_cycles(HALF);
      ps2_clk = 1'b0;
      if (i == 10 && pop_on_stop) begin
        wait_cycles(11);
        u_if.code_ready = 1'b1;
        wait_cycles(1);
        u_if.code_ready = 1'b0;
        wait_cycles(HALF - 12);
      end else begin
        wait_cycles(HALF);
      end
      ps2_clk = 1'b1;
    end
    wait_cycles(4);
    ps2_data = 1'b1;
    wait_cycles(6);
  endtask

  // First nbits of a frame; ps2_clk is left low after the last one.
  task automatic send_partial(input logic [7:0] code, input int nbits);
    logic [8:0] b;
    b = {code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1 ps2_data = b[i];
      wait_cycles(HALF);
      ps2_clk = 1'b0;
      wait_cycles(HALF);
      if (i != nbits - 1) ps2_clk = 1'b1;
    end
  endtask

  task automatic pop_one();
    u_if.code_ready = 1'b1;
    wait_cycles(1);
    u_if.code_ready = 1'b0;
    wait_cycles(1);
  endtask

  task automatic check_head(input string tag, input bit v, input logic [7:0] d,
                            input bit e, input bit k, input int cnt);
    @(negedge clk);
    check({tag, ".valid"}, int'(u_if.code_valid), int'(v));
    check({tag, ".data"},  int'(u_if.code_data),  int'(d));
    check({tag, ".ext"},   int'(u_if.code_ext),   int'(e));
    check({tag, ".brk"},   int'(u_if.code_break), int'(k));
    check({tag, ".count"}, int'(fifo_count),      cnt);
  endtask

  typedef struct {
    logic [7:0] code;
    bit         bad_par;
    bit         stop_bit;
    bit         exp_valid;
    logic [7:0] exp_data;
    bit         exp_ext;
    bit         exp_brk;
    int         exp_err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int e0, o0;
    string tag;
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 8'h1C, 1'b0, 1'b0, 0};
    vecs[1] = '{8'hE0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0};
    vecs[2] = '{8'hF0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0};
    vecs[3] = '{8'h75, 1'b0, 1'b1, 1'b1, 8'h75, 1'b1, 1'b1, 0};
    vecs[4] = '{8'h75, 1'b0, 1'b1, 1'b1, 8'h75, 1'b0, 1'b0, 0};
    vecs[5] = '{8'hF0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0};
    vecs[6] = '{8'h1C, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1};
    vecs[7] = '{8'h1C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1};
    vecs[8] = '{8'h32, 1'b0, 1'b1, 1'b1, 8'h32, 1'b0, 1'b0, 0};
    vecs[9] = '{8'hE1, 1'b0, 1'b1, 1'b1, 8'hE1, 1'b0, 1'b0, 0};

    u_if.code_ready = 1'b0;
    wait_cycles(5);
    reset = 1'b0;
    wait_cycles(2);

    check_head("reset", 1'b0, 8'h00, 1'b0, 1'b0, 0);
    check("reset.frame_err", int'(frame_err), 0);
    check("reset.overflow", int'(overflow), 0);

    // Table-driven single frames; each accepted event is popped afterwards.
    for (int i = 0; i < 10; i++) begin
      e0 = err_pulses;
      send_frame(vecs[i].code, vecs[i].bad_par, vecs[i].stop_bit, 1'b0);
      tag = $sformatf("vec%0d", i);
      check_head(tag, vecs[i].exp_valid, vecs[i].exp_data, vecs[i].exp_ext,
                 vecs[i].exp_brk, int'(vecs[i].exp_valid));
      check({tag, ".errs"}, err_pulses - e0, vecs[i].exp_err);
      if (vecs[i].exp_valid) begin
        pop_one();
        @(negedge clk);
        check({tag, ".popcnt"}, int'(fifo_count), 0);
      end
    end

    // Timeout: start + 4 data bits, then ps2_clk held low.
    e0 = err_pulses;
    send_partial(8'h29, 5);
    wait_cycles(TIMEOUT_CYCLES + 40);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_cycles(40);
    check("timeout.errs", err_pulses - e0, 1);
    send_frame(8'h29, 1'b0, 1'b1, 1'b0);
    check_head("after_to", 1'b1, 8'h29, 1'b0, 1'b0, 1);
    pop_one();

    // Overflow: nine codes with no consumer.
    o0 = ovf_pulses;
    for (int i = 0; i < FIFO_DEPTH + 1; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b1, 1'b0);
    check_head("full", 1'b1, 8'h10, 1'b0, 1'b0, 8);
    check("full.ovf", ovf_pulses - o0, 1);
    // Push coinciding with pop while full.
    send_frame(8'h19, 1'b0, 1'b1, 1'b1);
    check_head("pushpop", 1'b1, 8'h11, 1'b0, 1'b0, 8);
    check("pushpop.ovf", ovf_pulses - o0, 1);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      logic [7:0] exp_code;
      exp_code = (i == FIFO_DEPTH - 1) ? 8'h19 : 8'h11 + 8'(i);
      @(negedge clk);
      check($sformatf("drain%0d.data", i), int'(u_if.code_data), int'(exp_code));
      check($sformatf("drain%0d.count", i), int'(fifo_count), FIFO_DEPTH - i);
      wait_cycles(1);
      pop_one();
    end
    @(negedge clk);
    check("drained.valid", int'(u_if.code_valid), 0);

    // Short glitch with data low must not start a frame (no timeout follows).
    e0 = err_pulses;
    @(posedge clk); #1 ps2_data = 1'b0;
    ps2_clk = 1'b0;
    wait_cycles(FILTER_LEN - 2);
    ps2_clk = 1'b1;
    wait_cycles(30);
    ps2_data = 1'b1;
    wait_cycles(TIMEOUT_CYCLES + 50);
    check("glitch.errs", err_pulses - e0, 0);
    check("glitch.count", int'(fifo_count), 0);

    // Reset mid-prefix and mid-frame with a non-empty FIFO.
    send_frame(8'h29, 1'b0, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_partial(8'h5A, 4);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_cycles(2);
    check("pre_reset.count", int'(fifo_count), 1);
    reset = 1'b1;
    wait_cycles(3);
    check_head("in_reset", 1'b0, 8'h00, 1'b0, 1'b0, 0);
    reset = 1'b0;
    wait_cycles(2);
    check_head("post_reset", 1'b0, 8'h00, 1'b0, 1'b0, 0);
    check("post_reset.frame_err", int'(frame_err), 0);
    check("post_reset.overflow", int'(overflow), 0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check_head("after_rst", 1'b1, 8'h1C, 1'b0, 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
